// File: rtl/aes_sbox_pipe.sv
// Two-stage, multi-lane AES S-box pipeline with valid/ready handshakes.
// Define AES_SBOX_INV_EN to build in the inverse S-box and honour in_inv.
module aes_sbox_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [CNT_W-1:0]   word_cnt
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{bb[0]}});
            aa = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction
`endif

    logic               s1_valid_r;
    logic [8*LANES-1:0] s1_data_r;
    logic               s1_inv_r;
    logic               out_valid_r;
    logic [8*LANES-1:0] out_data_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic [8*LANES-1:0] sub_s;
    logic               adv2_s;
    logic               in_ready_s;
    logic               accept_s;

    assign adv2_s     = !out_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || adv2_s;
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign word_cnt   = word_cnt_r;

    // Per-lane substitution of the word held in S1
    always_comb begin
        sub_s = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef AES_SBOX_INV_EN
            if (s1_inv_r) begin
                sub_s[8*l +: 8] = sbox_inv(s1_data_r[8*l +: 8]);
            end else begin
                sub_s[8*l +: 8] = sbox_fwd(s1_data_r[8*l +: 8]);
            end
`else
            sub_s[8*l +: 8] = sbox_fwd(s1_data_r[8*l +: 8]);
`endif
        end
    end

`ifdef AES_SBOX_INV_EN
    // S1 register: captures the offered word and its direction flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_inv_r   <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            s1_data_r  <= in_valid ? in_data : '0;
            s1_inv_r   <= in_valid & in_inv;
        end
    end
`else
    logic unused_inv_s;
    assign unused_inv_s = in_inv;
    assign s1_inv_r     = 1'b0;

    // S1 register: captures the offered word (forward-only build)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            s1_data_r  <= in_valid ? in_data : '0;
        end
    end
`endif

    // S2 register: result is zeroed whenever no valid word moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            out_data_r  <= s1_valid_r ? sub_s : '0;
        end
    end

    // Accepted-word counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r <= '0;
        end else if (accept_s) begin
            word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
        end
    end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: hand vectors, stall/stream sweeps, reset.
// Golden results come from the FIPS-197 forward table; inverse is derived from it.
module tb_aes_sbox_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_inv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_cnt;
    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic [3:0]  word_cnt4;

    int checks = 0;
    int errors = 0;

    aes_sbox_pipe #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .word_cnt(word_cnt)
    );

    aes_sbox_pipe #(.LANES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .word_cnt(word_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    typedef struct {
        logic [31:0] d;
        logic        inv;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    // Reference pipeline state (occupancy, expected contents, counters)
    logic        m_s1v, m_ov;
    logic [31:0] m_q1, m_q2;
    int          m_cnt;
    int          n_out;
    int          stream_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
`ifdef AES_SBOX_INV_EN
            r[8*l +: 8] = inv ? inv_t[d[8*l +: 8]] : fwd_t[d[8*l +: 8]];
`else
            r[8*l +: 8] = inv ? fwd_t[d[8*l +: 8]] : fwd_t[d[8*l +: 8]];
`endif
        end
        return r;
    endfunction

    function automatic logic [31:0] pat(input int i);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'(i + 64 * l);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // One clock: drive inputs, compare outputs to the reference, advance reference
    task automatic do_cycle(input logic v, input logic [31:0] d, input logic inv,
                            input logic ordy, output logic acc);
        logic exp_ir;
        logic adv2;
        in_valid  = v;
        in_data   = v ? d : 32'h0;
        in_inv    = inv;
        out_ready = ordy;
        #1;
        exp_ir = !m_s1v || !m_ov || ordy;
        adv2   = !m_ov || ordy;
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ir});
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        chk("out_data", out_data, m_ov ? m_q2 : 32'h0);
        chk("out_data_c4", out_data4, m_ov ? m_q2 : 32'h0);
        chk("word_cnt", {16'h0, word_cnt}, 32'(m_cnt % 65536));
        chk("word_cnt_w4", {28'h0, word_cnt4}, 32'(m_cnt % 16));
        if (m_ov && ordy) begin
            if (stream_base >= 0)
                chk("stream_order", m_q2, 32'h0);
            n_out++;
        end
        if (adv2) begin
            m_ov = m_s1v;
            m_q2 = m_q1;
        end
        acc = v && exp_ir;
        if (exp_ir) begin
            m_s1v = v;
            m_q1  = exp_word(d, inv);
            if (v) m_cnt++;
        end
        @(posedge clk);
        #2;
    endtask

    // Stream 0x00..0xFF on every lane (lane-rotated); modes vary direction/backpressure
    task automatic run_stream(input int mode);
        int          idx;
        int          cyc;
        int          got;
        int          first_out;
        logic        acc;
        logic        ordy;
        logic        inv;
        logic [31:0] want;
        idx = 0;
        cyc = 0;
        got = 0;
        first_out = n_out;
        while ((idx < 256 || m_s1v || m_ov) && cyc < 2000) begin
            case (mode)
                0:       begin ordy = !(cyc >= 3 && cyc <= 7); inv = 1'b0; end
                1:       begin ordy = 1'b1; inv = 1'b1; end
                default: begin ordy = ($urandom_range(0, 3) != 0); inv = idx[0]; end
            endcase
            if (m_ov && ordy) begin
                // independent ordering check: k-th result must be word k of the stream
                want = exp_word(pat(got), (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : got[0]);
                #1;
                chk("stream_seq", out_data, want);
                #0;
                got++;
            end
            do_cycle(idx < 256, pat(idx), inv, ordy, acc);
            if (acc) idx++;
            cyc++;
        end
        if (cyc >= 2000) chk("stream_timeout", 32'(cyc), 32'(0));
        chk("stream_count", 32'(n_out - first_out), 32'd256);
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < 256; i++) fwd_t[i] = SBOX_HEX[2047 - 8*i -: 8];
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        vecs[0] = '{32'h530100FF, 1'b0, 32'hED7C6316};
`ifdef AES_SBOX_INV_EN
        vecs[1] = '{32'h16637CED, 1'b1, 32'hFF000153};
        vecs[5] = '{32'h63636363, 1'b1, 32'h00000000};
`else
        vecs[1] = '{32'h16637CED, 1'b1, 32'h47FB1055};
        vecs[5] = '{32'h63636363, 1'b1, 32'hFBFBFBFB};
`endif
        vecs[2] = '{32'h00000000, 1'b0, 32'h63636363};
        vecs[3] = '{32'hFFFFFFFF, 1'b0, 32'h16161616};
        vecs[4] = '{32'h10203040, 1'b0, 32'hCAB70409};
        vecs[6] = '{32'h01234567, 1'b0, 32'h7C266E85};

        m_s1v = 1'b0; m_ov = 1'b0; m_q1 = 32'h0; m_q2 = 32'h0;
        m_cnt = 0; n_out = 0; stream_base = -1;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_inv = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_word_cnt", {16'h0, word_cnt}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Hand vectors, one word at a time
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = vecs[k].d; in_inv = vecs[k].inv; out_ready = 1'b1;
            #1;
            chk("vec_in_ready", {31'h0, in_ready}, 32'h1);
            tick();
            in_valid = 1'b0; in_data = 32'h0; in_inv = 1'b0;
            chk("vec_lat1_valid", {31'h0, out_valid}, 32'h0);
            tick();
            chk("vec_valid", {31'h0, out_valid}, 32'h1);
            chk("vec_data", out_data, vecs[k].exp);
            chk("vec_word_cnt", {16'h0, word_cnt}, 32'(k + 1));
            tick();
            chk("vec_drain_valid", {31'h0, out_valid}, 32'h0);
            chk("vec_drain_data", out_data, 32'h0);
        end
        m_cnt = 7;

        run_stream(0);
        chk("cnt_w4_wrap", {28'h0, word_cnt4}, 32'((7 + 256) % 16));
        run_stream(1);
        run_stream(2);

        // Reset with both stages full
        do_cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, acc);
        do_cycle(1'b1, 32'h3C3C3C3C, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        chk("full_out_valid", {31'h0, out_valid}, 32'h1);
        chk("full_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_word_cnt", {16'h0, word_cnt}, 32'h0);
        chk("mid_rst_word_cnt4", {28'h0, word_cnt4}, 32'h0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        m_s1v = 1'b0; m_ov = 1'b0; m_q1 = 32'h0; m_q2 = 32'h0; m_cnt = 0;
        repeat (3) do_cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        do_cycle(1'b1, 32'h530100FF, 1'b0, 1'b1, acc);
        repeat (3) do_cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
